mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory between the instruction-fetch port (port 0) and the load/store port (port 1). It accepts held request/done handshakes from each requester and grants one access at a time, round-robin on contention. It drives the memory's MemRead/MemWrite/Address/WriteData pins and captures the registered ReadData. The block sits between the CPU control path and the memory.

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals shared by the two-port arbiter.
// slave is the arbiter side; master is the requesters plus memory.
interface mem_arbiter_if #(
  parameter int WORD = 32
);
  logic            p0_req;
  logic            p0_we;
  logic [WORD-1:0] p0_addr;
  logic [WORD-1:0] p0_wdata;
  logic            p0_done;
  logic [WORD-1:0] p0_rdata;
  logic            p1_req;
  logic            p1_we;
  logic [WORD-1:0] p1_addr;
  logic [WORD-1:0] p1_wdata;
  logic            p1_done;
  logic [WORD-1:0] p1_rdata;
  logic            mem_read;
  logic            mem_write;
  logic [WORD-1:0] mem_addr;
  logic [WORD-1:0] mem_wdata;
  logic [WORD-1:0] mem_rdata;
  logic            busy;
  logic            gnt_id;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_done, p0_rdata, p1_done, p1_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output busy, gnt_id
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_done, p0_rdata, p1_done, p1_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  busy, gnt_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between
// instruction fetch (port 0) and load/store (port 1).
module mem_arbiter #(
  parameter int WORD      = 32,
  parameter int ADDR_BITS = 5
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic last_q, last_d;
  logic gnt_q, gnt_d;
  logic we_q, we_d;

  logic            rd_d, wr_d;
  logic            done0_d, done1_d;
  logic            busy_d;
  logic [WORD-1:0] addr_d, wdata_d;
  logic [WORD-1:0] rdata0_d, rdata1_d;

  logic            sel;
  logic            sel_we;
  logic [WORD-1:0] sel_addr;
  logic [WORD-1:0] sel_wdata;
  logic            unused_hi;

  // On a tie the port that did not win last time is served.
  assign sel = (bus.p0_req & bus.p1_req) ? ~last_q : bus.p1_req;

  assign sel_we    = sel ? bus.p1_we    : bus.p0_we;
  assign sel_addr  = sel ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = sel ? bus.p1_wdata : bus.p0_wdata;

  assign unused_hi = ^{bus.p0_addr[WORD-1:ADDR_BITS],
                       bus.p1_addr[WORD-1:ADDR_BITS]};

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = bus.p0_rdata;
    rdata1_d = bus.p1_rdata;
    unique case (state_q)
      IDLE: begin
        if (bus.p0_req | bus.p1_req) begin
          state_d = ISSUE;
          gnt_d   = sel;
          last_d  = sel;
          we_d    = sel_we;
          rd_d    = ~sel_we;
          wr_d    = sel_we;
          addr_d  = {{(WORD-ADDR_BITS){1'b0}},
                     sel_addr[ADDR_BITS-1:0]};
          wdata_d = sel_we ? sel_wdata : '0;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
          done0_d = ~gnt_q;
          done1_d = gnt_q;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d = DONE;
        done0_d = ~gnt_q;
        done1_d = gnt_q;
        if (gnt_q) rdata1_d = bus.mem_rdata;
        else       rdata0_d = bus.mem_rdata;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      gnt_q         <= 1'b0;
      we_q          <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.p0_done   <= 1'b0;
      bus.p1_done   <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_rdata  <= '0;
      bus.busy      <= 1'b0;
      bus.gnt_id    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      gnt_q         <= gnt_d;
      we_q          <= we_d;
      bus.mem_read  <= rd_d;
      bus.mem_write <= wr_d;
      bus.mem_addr  <= addr_d;
      bus.mem_wdata <= wdata_d;
      bus.p0_done   <= done0_d;
      bus.p1_done   <= done1_d;
      bus.p0_rdata  <= rdata0_d;
      bus.p1_rdata  <= rdata1_d;
      bus.busy      <= busy_d;
      bus.gnt_id    <= gnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read memory model.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  mem_arbiter_if #(.WORD(32)) bus ();

  mem_arbiter #(
    .WORD      (32),
    .ADDR_BITS (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [32];
  logic [31:0] rd_q;
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_write) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    if (bus.mem_read) rd_q <= mem[bus.mem_addr[4:0]];
  end

  assign bus.mem_rdata = rd_q;

  function automatic logic [133:0] outs();
    return {bus.mem_read, bus.mem_write, bus.mem_addr,
            bus.mem_wdata, bus.p0_done, bus.p1_done,
            bus.p0_rdata, bus.p1_rdata, bus.busy, bus.gnt_id};
  endfunction

  task automatic idle_ports();
    bus.p0_req = 0; bus.p0_we = 0;
    bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 0; bus.p1_we = 0;
    bus.p1_addr = '0; bus.p1_wdata = '0;
  endtask

  task automatic apply_reset();
    idle_ports();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pl_en = 1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_ports();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs() !== '0)
      $display("FAIL reset_outs: got %h want 0", outs());
    else passed++;
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if (outs() !== '0)
      $display("FAIL idle_outs: got %h want 0", outs());
    else passed++;
  endtask

  task automatic test_single_read();
    preload(5'd3, 32'hDEAD_BEEF);
    apply_reset();
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'd3;
    @(negedge clk);
    checks++;
    if (bus.mem_read !== 0)
      $display("FAIL rd_n_memread: got %b want 0", bus.mem_read);
    else passed++;
    @(negedge clk);
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.mem_addr}
        !== {1'b1, 1'b0, 32'd3})
      $display("FAIL rd_issue: got %b%b %h want 10 3",
               bus.mem_read, bus.mem_write, bus.mem_addr);
    else passed++;
    @(negedge clk);
    checks++;
    if ({bus.mem_read, bus.p0_done, bus.busy} !== 3'b001)
      $display("FAIL rd_wait: got %b%b%b want 001",
               bus.mem_read, bus.p0_done, bus.busy);
    else passed++;
    @(negedge clk);
    bus.p0_req = 0;
    checks++;
    if ({bus.p0_done, bus.p1_done, bus.p0_rdata}
        !== {2'b10, 32'hDEAD_BEEF})
      $display("FAIL rd_done: got %b%b %h want 10 deadbeef",
               bus.p0_done, bus.p1_done, bus.p0_rdata);
    else passed++;
    @(negedge clk);
    checks++;
    if ({bus.p0_done, bus.busy, bus.p0_rdata}
        !== {2'b00, 32'hDEAD_BEEF})
      $display("FAIL rd_after: got %b%b %h want 00 deadbeef",
               bus.p0_done, bus.busy, bus.p0_rdata);
    else passed++;
  endtask

  task automatic test_write_read();
    apply_reset();
    bus.p1_req = 1; bus.p1_we = 1;
    bus.p1_addr = 32'd7; bus.p1_wdata = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata}
        !== {2'b10, 32'd7, 32'h1234_5678})
      $display("FAIL wr_issue: got %b%b %h %h want 10 7 12345678",
               bus.mem_write, bus.mem_read,
               bus.mem_addr, bus.mem_wdata);
    else passed++;
    @(negedge clk);
    bus.p1_req = 0;
    checks++;
    if ({bus.p1_done, bus.p0_done, bus.mem_write, bus.gnt_id}
        !== 4'b1001)
      $display("FAIL wr_done: got %b%b%b%b want 1001",
               bus.p1_done, bus.p0_done,
               bus.mem_write, bus.gnt_id);
    else passed++;
    checks++;
    if (mem[7] !== 32'h1234_5678)
      $display("FAIL wr_mem: got %h want 12345678", mem[7]);
    else passed++;
    @(posedge clk); #1;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'd7;
    repeat (4) @(negedge clk);
    bus.p1_req = 0;
    checks++;
    if ({bus.p1_done, bus.p1_rdata} !== {1'b1, 32'h1234_5678})
      $display("FAIL wr_readback: got %b %h want 1 12345678",
               bus.p1_done, bus.p1_rdata);
    else passed++;
  endtask

  task automatic test_contention();
    logic [3:0] exp;
    preload(5'd4, 32'hAAAA_0004);
    preload(5'd5, 32'hBBBB_0005);
    apply_reset();
    bus.p0_req = 1; bus.p0_addr = 32'd4;
    bus.p1_req = 1; bus.p1_addr = 32'd5;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp[3] = (k == 3) || (k == 11);
      exp[2] = (k == 7) || (k == 15);
      exp[1] = (k % 4) == 1;
      exp[0] = (k == 0) ? 1'b0 : 1'(((k - 1) / 4) % 2);
      checks++;
      if ({bus.p0_done, bus.p1_done, bus.mem_read, bus.gnt_id}
          !== exp)
        $display("FAIL rr_cycle%0d: got %b%b%b%b want %b", k,
                 bus.p0_done, bus.p1_done,
                 bus.mem_read, bus.gnt_id, exp);
      else passed++;
      checks++;
      if (bus.busy !== ((k % 4) != 0))
        $display("FAIL rr_busy%0d: got %b want %b", k,
                 bus.busy, (k % 4) != 0);
      else passed++;
    end
    bus.p0_req = 0; bus.p1_req = 0;
    checks++;
    if ({bus.p0_rdata, bus.p1_rdata}
        !== {32'hAAAA_0004, 32'hBBBB_0005})
      $display("FAIL rr_rdata: got %h %h want aaaa0004 bbbb0005",
               bus.p0_rdata, bus.p1_rdata);
    else passed++;
  endtask

  task automatic test_exclusive();
    int bad;
    bad = 0;
    apply_reset();
    for (int c = 0; c < 1000; c++) begin
      bus.p0_req   = 1'($urandom_range(0, 1));
      bus.p0_we    = 1'($urandom_range(0, 1));
      bus.p0_addr  = 32'($urandom_range(8, 15)) | 32'hF000_0000;
      bus.p0_wdata = $urandom;
      bus.p1_req   = 1'($urandom_range(0, 1));
      bus.p1_we    = 1'($urandom_range(0, 1));
      bus.p1_addr  = 32'($urandom_range(8, 15));
      bus.p1_wdata = $urandom;
      @(negedge clk);
      if ((bus.mem_read & bus.mem_write) !== 1'b0 ||
          (bus.p0_done & bus.p1_done) !== 1'b0 ||
          bus.mem_addr[31:5] !== '0)
        bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 0)
      $display("FAIL exclusive: got %0d bad cycles want 0", bad);
    else passed++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; bus.p0_req = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if (outs() !== '0)
      $display("FAIL mid_reset_outs: got %h want 0", outs());
    else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.p0_done, bus.busy} !== 2'b00)
        $display("FAIL mid_no_done%0d: got %b%b want 00", k,
                 bus.p0_done, bus.busy);
      else passed++;
    end
    @(posedge clk); #1;
    bus.p0_req = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.p0_done !== 1'b0)
      $display("FAIL mid_early: got %b want 0", bus.p0_done);
    else passed++;
    @(negedge clk);
    bus.p0_req = 0;
    checks++;
    if ({bus.p0_done, bus.p0_rdata} !== {1'b1, 32'hDEAD_BEEF})
      $display("FAIL mid_relatency: got %b %h want 1 deadbeef",
               bus.p0_done, bus.p0_rdata);
    else passed++;
  endtask

  task automatic test_addr_wrap();
    apply_reset();
    bus.p0_req = 1; bus.p0_we = 1;
    bus.p0_addr = 32'h21; bus.p0_wdata = 32'hA5;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.mem_write, bus.mem_addr, bus.mem_wdata}
        !== {1'b1, 32'd1, 32'hA5})
      $display("FAIL wrap_issue: got %b %h %h want 1 1 a5",
               bus.mem_write, bus.mem_addr, bus.mem_wdata);
    else passed++;
    @(negedge clk);
    bus.p0_req = 0;
    checks++;
    if (bus.p0_done !== 1'b1)
      $display("FAIL wrap_done: got %b want 1", bus.p0_done);
    else passed++;
    @(posedge clk); #1;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'd1;
    repeat (4) @(negedge clk);
    bus.p0_req = 0;
    checks++;
    if ({bus.p0_done, bus.p0_rdata} !== {1'b1, 32'hA5})
      $display("FAIL wrap_read: got %b %h want 1 a5",
               bus.p0_done, bus.p0_rdata);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    pl_en = 0; pl_addr = '0; pl_data = '0;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_exclusive();
    test_reset_mid();
    test_addr_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
